bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive cycles M1 may own the bus while m0_req is pending (legal range 2..255).
REQ-002 The block SHALL provide these ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  bus request, master 0 (host/testbench).
- m0_wr  in  1  write strobe, master 0.
- m0_address  in  16  address, master 0.
- m0_dout  in  32  write data, master 0.
- m1_req  in  1  bus request, master 1 (DMAC master port).
- m1_wr  in  1  write strobe, master 1.
- m1_address  in  16  address, master 1.
- m1_dout  in  32  write data, master 1.
- m0_grant  out  1  bus owned by master 0.
- m1_grant  out  1  bus owned by master 1.
- m_din  out  32  read data returned to both masters.
- s0_sel..s4_sel  out  1 each  slave selects: DMAC, ALU, OPERAND, INSTRUCTION, RESULT.
- s_wr  out  1  write strobe to slaves.
- s_address  out  16  address to slaves.
- s_din  out  32  write data to slaves.
- s0_dout..s4_dout  in  32 each  read data from slaves 0..4.

Function
REQ-003 FSM states: M0_GRANT, M1_GRANT; exactly one grant SHALL be high at all times, registered from the state.
REQ-004 In M0_GRANT, the FSM SHALL move to M1_GRANT only when m0_req=0 and m1_req=1; otherwise it SHALL stay.
REQ-005 In M1_GRANT, the FSM SHALL return to M0_GRANT when m1_req=0, or when hold_cnt reaches MAX_HOLD with m0_req=1; otherwise it SHALL stay.
REQ-006 Grant latency SHALL be one cycle: the request sampled at edge N produces a grant change visible after edge N.
REQ-007 hold_cnt (8 bit) SHALL clear on every entry to M1_GRANT, increment each cycle in M1_GRANT while m0_req=1, saturate at MAX_HOLD, and hold otherwise.
REQ-008 After a forced return (REQ-005 timeout), M1 SHALL NOT be re-granted until m0_req has been sampled low for at least one cycle.
REQ-009 s_address, s_wr and s_din SHALL combinationally mux the granted master's signals; s_wr SHALL be gated by that master's req.
REQ-010 Decode (combinational, on s_address, gated by granted req): 0x0000-0x001F -> s0, 0x0100-0x011F -> s1, 0x0200-0x023F -> s2, 0x0300-0x033F -> s3, 0x0400-0x043F -> s4; at most one select high.
REQ-011 Unmapped addresses SHALL assert no select, and writes to them SHALL be dropped.
REQ-012 The read slave index SHALL be registered one cycle; m_din SHALL be the registered slave's dout, or 0x0000_0000 if the previous cycle was unmapped or had no request.
REQ-013 Simultaneous m0_req=1 and m1_req=1 in M0_GRANT SHALL keep M0; master 0 has fixed priority at idle.

Reset
REQ-014 While reset=1 at a clock edge: state=M0_GRANT, m0_grant=1, m1_grant=0, hold_cnt=0, registered read index=none (m_din=0), and the REQ-008 lockout flag=0.
REQ-015 Reset asserted mid-transfer SHALL abort M1 ownership on that edge, with no further writes issued from M1.

Structure
REQ-016 A shared package SHALL hold the state encoding, the slave index enum, and the five address base/limit constants, which the DMAC and testbench also use.
REQ-017 One sub-module, bus_addr_decoder (address -> one-hot select and index), SHALL be instantiated; arbitration and muxing reside in bus_arbiter.

Verification
REQ-018 After reset, with no requests: m0_grant=1, m1_grant=0, m_din=0.
REQ-019 m0_req=0 and m1_req=1 at edge N: m1_grant=1 after edge N. m1 writes 0x1234_5678 to 0x0300: s3_sel=1, s_wr=1, s_din=0x1234_5678.
REQ-020 m1 owns the bus, m0_req=1 held, MAX_HOLD=16: m1_grant drops after 16 cycles and m0_grant rises; M1 is not re-granted until m0_req falls.
REQ-021 m0 reads 0x0204 with s2_dout=0x9012_3456: m_din=0x9012_3456 one cycle later. m0 reads 0x0050 (unmapped): no select, m_din=0.
REQ-022 Both masters request from idle: M0 is kept. reset=1 during an M1 write burst: m0_grant=1 on the next edge and s_wr from M1 stops.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master system bus: arbiter state encoding,
// slave index encoding and the slave address windows.
package bus_arbiter_pkg;

   typedef enum logic {
      M0_GRANT = 1'b0,
      M1_GRANT = 1'b1
   } arb_state_e;

   typedef enum logic [2:0] {
      SLV_DMAC   = 3'd0,
      SLV_ALU    = 3'd1,
      SLV_OPND   = 3'd2,
      SLV_INSTR  = 3'd3,
      SLV_RESULT = 3'd4,
      SLV_NONE   = 3'd7
   } slave_idx_e;

   localparam int NUM_SLAVES = 5;

   localparam logic [15:0] S0_BASE  = 16'h0000;
   localparam logic [15:0] S0_LIMIT = 16'h001F;
   localparam logic [15:0] S1_BASE  = 16'h0100;
   localparam logic [15:0] S1_LIMIT = 16'h011F;
   localparam logic [15:0] S2_BASE  = 16'h0200;
   localparam logic [15:0] S2_LIMIT = 16'h023F;
   localparam logic [15:0] S3_BASE  = 16'h0300;
   localparam logic [15:0] S3_LIMIT = 16'h033F;
   localparam logic [15:0] S4_BASE  = 16'h0400;
   localparam logic [15:0] S4_LIMIT = 16'h043F;

   // Inclusive window test used by the decoder.
   function automatic logic in_range(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
      return (addr >= base) && (addr <= limit);
   endfunction

endpackage

// File: rtl/bus_arbiter_addr_decoder.sv
// Address decoder: maps the bus address onto a one-hot slave select and a
// slave index. Everything is forced idle when en is low.
module bus_addr_decoder
   import bus_arbiter_pkg::*;
(
   input  logic                  en,
   input  logic [15:0]           address,
   output logic [NUM_SLAVES-1:0] sel,
   output slave_idx_e            idx,
   output logic                  hit
);

   // Priority chain over disjoint windows, so at most one select can be high.
   always_comb begin
      sel = '0;
      idx = SLV_NONE;
      if (en) begin
         if (in_range(address, S0_BASE, S0_LIMIT)) begin
            sel[0] = 1'b1;
            idx    = SLV_DMAC;
         end else if (in_range(address, S1_BASE, S1_LIMIT)) begin
            sel[1] = 1'b1;
            idx    = SLV_ALU;
         end else if (in_range(address, S2_BASE, S2_LIMIT)) begin
            sel[2] = 1'b1;
            idx    = SLV_OPND;
         end else if (in_range(address, S3_BASE, S3_LIMIT)) begin
            sel[3] = 1'b1;
            idx    = SLV_INSTR;
         end else if (in_range(address, S4_BASE, S4_LIMIT)) begin
            sel[4] = 1'b1;
            idx    = SLV_RESULT;
         end
      end
      hit = |sel;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter. Master 0 has priority at idle; master 1 may keep
// the bus against a pending master-0 request for at most MAX_HOLD cycles,
// after which it is locked out until master 0 drops its request.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [15:0] m0_address,
   input  logic [31:0] m0_dout,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [15:0] m1_address,
   input  logic [31:0] m1_dout,
   output logic        m0_grant,
   output logic        m1_grant,
   output logic [31:0] m_din,
   output logic        s0_sel,
   output logic        s1_sel,
   output logic        s2_sel,
   output logic        s3_sel,
   output logic        s4_sel,
   output logic        s_wr,
   output logic [15:0] s_address,
   output logic [31:0] s_din,
   input  logic [31:0] s0_dout,
   input  logic [31:0] s1_dout,
   input  logic [31:0] s2_dout,
   input  logic [31:0] s3_dout,
   input  logic [31:0] s4_dout
);

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   arb_state_e state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       lockout_q, lockout_d;
   slave_idx_e rd_idx_q, rd_idx_d;

   logic                  gnt_req;
   logic                  gnt_wr;
   logic [NUM_SLAVES-1:0] dec_sel;
   slave_idx_e            dec_idx;
   logic                  dec_hit;

   // Next-state: release on m1_req drop, or forced return on the edge where
   // the hold count reaches MAX_HOLD while master 0 is still waiting.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      lockout_d  = lockout_q;
      case (state_q)
         M0_GRANT: begin
            if (!m0_req) lockout_d = 1'b0;
            if (!m0_req && m1_req && !lockout_q) begin
               state_d    = M1_GRANT;
               hold_cnt_d = '0;
            end
         end
         M1_GRANT: begin
            if (m0_req && hold_cnt_q < HOLD_MAX) hold_cnt_d = hold_cnt_q + 8'd1;
            if (!m1_req) begin
               state_d = M0_GRANT;
            end else if (m0_req && hold_cnt_q >= HOLD_MAX - 8'd1) begin
               state_d   = M0_GRANT;
               lockout_d = 1'b1;
            end
         end
         default: state_d = M0_GRANT;
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= M0_GRANT;
         hold_cnt_q <= '0;
         lockout_q  <= 1'b0;
         rd_idx_q   <= SLV_NONE;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         lockout_q  <= lockout_d;
         rd_idx_q   <= rd_idx_d;
      end
   end

   assign m0_grant = (state_q == M0_GRANT);
   assign m1_grant = (state_q == M1_GRANT);

   // Route the granted master onto the slave side.
   always_comb begin
      gnt_req   = m1_grant ? m1_req     : m0_req;
      gnt_wr    = m1_grant ? m1_wr      : m0_wr;
      s_address = m1_grant ? m1_address : m0_address;
      s_din     = m1_grant ? m1_dout    : m0_dout;
   end

   bus_addr_decoder u_dec (
      .en      (gnt_req),
      .address (s_address),
      .sel     (dec_sel),
      .idx     (dec_idx),
      .hit     (dec_hit)
   );

   assign {s4_sel, s3_sel, s2_sel, s1_sel, s0_sel} = dec_sel;
   // Writes to unmapped space never reach a slave.
   assign s_wr     = gnt_req & gnt_wr & dec_hit;
   assign rd_idx_d = dec_idx;

   // Read data returns one cycle after the address phase.
   always_comb begin
      m_din = '0;
      case (rd_idx_q)
         SLV_DMAC:   m_din = s0_dout;
         SLV_ALU:    m_din = s1_dout;
         SLV_OPND:   m_din = s2_dout;
         SLV_INSTR:  m_din = s3_dout;
         SLV_RESULT: m_din = s4_dout;
         default:    m_din = '0;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, grant handover, hold timeout and
// lockout, decode windows, read return path, and reset during an M1 burst.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [15:0] m0_address, m1_address;
   logic [31:0] m0_dout, m1_dout;
   logic        m0_grant, m1_grant;
   logic [31:0] m_din;
   logic        s0_sel, s1_sel, s2_sel, s3_sel, s4_sel, s_wr;
   logic [15:0] s_address;
   logic [31:0] s_din;
   logic [31:0] s0_dout = 32'hA000_0000;
   logic [31:0] s1_dout = 32'hA111_1111;
   logic [31:0] s2_dout = 32'h9012_3456;
   logic [31:0] s3_dout = 32'hA333_3333;
   logic [31:0] s4_dout = 32'hA444_4444;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.MAX_HOLD(16)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
      .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
      .s0_sel(s0_sel), .s1_sel(s1_sel), .s2_sel(s2_sel), .s3_sel(s3_sel), .s4_sel(s4_sel),
      .s_wr(s_wr), .s_address(s_address), .s_din(s_din),
      .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout),
      .s3_dout(s3_dout), .s4_dout(s4_dout)
   );

   function automatic logic [4:0] sels();
      return {s4_sel, s3_sel, s2_sel, s1_sel, s0_sel};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct { logic [15:0] addr; logic [4:0] sel; } dec_vec_t;
   dec_vec_t dvec[8];

   initial begin
      dvec[0] = '{16'h001F, 5'b00001};
      dvec[1] = '{16'h0020, 5'b00000};
      dvec[2] = '{16'h0100, 5'b00010};
      dvec[3] = '{16'h011F, 5'b00010};
      dvec[4] = '{16'h0120, 5'b00000};
      dvec[5] = '{16'h023F, 5'b00100};
      dvec[6] = '{16'h043F, 5'b10000};
      dvec[7] = '{16'h0440, 5'b00000};

      reset = 1'b1;
      m0_req = 0; m0_wr = 0; m0_address = '0; m0_dout = '0;
      m1_req = 0; m1_wr = 0; m1_address = '0; m1_dout = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("reset_m0_grant", 32'(m0_grant), 32'd1);
      check("reset_m1_grant", 32'(m1_grant), 32'd0);
      check("reset_m_din", m_din, 32'h0);

      // M1 requests alone: granted after one edge, write routed to s3.
      m1_req = 1; m1_wr = 1; m1_address = 16'h0300; m1_dout = 32'h1234_5678;
      #1;
      check("pre_grant_s_wr", 32'(s_wr), 32'd0);
      tick();
      check("m1_grant", 32'(m1_grant), 32'd1);
      check("m1_grant_m0_low", 32'(m0_grant), 32'd0);
      check("m1_wr_sel", 32'(sels()), 32'b01000);
      check("m1_wr_s_wr", 32'(s_wr), 32'd1);
      check("m1_wr_s_din", s_din, 32'h1234_5678);
      check("m1_wr_s_addr", 32'(s_address), 32'h0300);

      // M0 waits: M1 keeps the bus for 16 cycles, then is forced off.
      m0_req = 1; m0_wr = 0; m0_address = 16'h0050;
      for (int i = 0; i < 15; i++) tick();
      check("hold_15_m1", 32'(m1_grant), 32'd1);
      tick();
      check("hold_16_m1", 32'(m1_grant), 32'd0);
      check("hold_16_m0", 32'(m0_grant), 32'd1);
      tick();
      check("lockout_m0_busy", 32'(m0_grant), 32'd1);
      m0_req = 0;
      tick();
      check("lockout_first_low", 32'(m0_grant), 32'd1);
      tick();
      check("lockout_released", 32'(m1_grant), 32'd1);
      m1_req = 0; m1_wr = 0;
      tick();
      check("m1_release", 32'(m0_grant), 32'd1);

      // M0 read of s2 with one-cycle return.
      m0_req = 1; m0_wr = 0; m0_address = 16'h0204;
      #1;
      check("rd_s2_sel", 32'(sels()), 32'b00100);
      check("rd_s2_no_wr", 32'(s_wr), 32'd0);
      tick();
      check("rd_s2_m_din", m_din, 32'h9012_3456);
      m0_address = 16'h0050;
      #1;
      check("unmapped_sel", 32'(sels()), 32'd0);
      tick();
      check("unmapped_m_din", m_din, 32'h0);
      m0_wr = 1;
      #1;
      check("unmapped_wr_drop", 32'(s_wr), 32'd0);
      m0_wr = 0; m0_address = 16'h0400;
      tick();
      check("rd_s4_m_din", m_din, 32'hA444_4444);
      m0_req = 0; m0_address = 16'h0204;
      #1;
      check("noreq_sel", 32'(sels()), 32'd0);
      tick();
      check("noreq_m_din", m_din, 32'h0);

      // Window boundaries.
      m0_req = 1;
      for (int i = 0; i < 8; i++) begin
         m0_address = dvec[i].addr;
         #1;
         check($sformatf("dec_%h", dvec[i].addr), 32'(sels()), 32'(dvec[i].sel));
      end

      // Both request from idle: master 0 keeps the bus.
      m1_req = 1;
      tick();
      check("both_req_m0", 32'(m0_grant), 32'd1);
      tick();
      check("both_req_m0_2", 32'(m1_grant), 32'd0);

      // Reset during an M1 write burst.
      m0_req = 0; m1_wr = 1; m1_address = 16'h0100; m1_dout = 32'hCAFE_0001;
      tick();
      check("burst_m1_grant", 32'(m1_grant), 32'd1);
      check("burst_s_wr", 32'(s_wr), 32'd1);
      check("burst_s1_sel", 32'(sels()), 32'b00010);
      tick();
      reset = 1;
      tick();
      check("rst_abort_m0", 32'(m0_grant), 32'd1);
      check("rst_abort_m1", 32'(m1_grant), 32'd0);
      check("rst_abort_s_wr", 32'(s_wr), 32'd0);
      check("rst_abort_m_din", m_din, 32'h0);
      reset = 0; m1_req = 0; m1_wr = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
